mult_8b_seq: RTL and testbench

Sequential 8x8 unsigned shift-add multiplier that sits on the operand side of `ula_8b`. It drives the ALU's `a`/`b`/`x`/`y` inputs and consumes its `s` and `c` outputs, one partial product per clock. A start/busy/done handshake lets a controller launch a product and collect a 16-bit result. It is the first `Multiplicador` block built on top of the 8-bit ALU.

---
 rtl/mult_pkg.sv | 26 ++
 rtl/ula_8b.sv | 39 +++
 rtl/mult_8b_seq.sv | 106 ++++++++++
 tb/tb_mult_8b_seq.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// ============================================================================
// mult_pkg
// Shared types and constants for the sequential shift-add multiplier.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // ALU opcodes as {x,y}
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_OR  = 2'b10;
  localparam logic [1:0] OP_NOT = 2'b11;

  localparam logic [3:0] ITER_LAST = 4'd7;

endpackage

`default_nettype wire

// File: rtl/ula_8b.sv
// ============================================================================
// ula_8b
// 8-bit combinational ALU: ADD / AND / OR / NOT selected by {x,y}.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ula_8b
  import mult_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       x,
  input  logic       y,
  output logic [7:0] s,
  output logic       c,
  output logic       ov,
  output logic       n
);

  always_comb begin
    s  = 8'h00;
    c  = 1'b0;
    ov = 1'b0;
    case ({x, y})
      OP_ADD: begin
        {c, s} = {1'b0, a} + {1'b0, b};
        ov     = (a[7] == b[7]) && (s[7] != a[7]);
      end
      OP_AND:  s = a & b;
      OP_OR:   s = a | b;
      default: s = ~a;
    endcase
    n = s[7];
  end

endmodule

`default_nettype wire

// File: rtl/mult_8b_seq.sv
// ============================================================================
// mult_8b_seq
// Sequential 8x8 unsigned shift-add multiplier built around ula_8b.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_8b_seq
  import mult_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] p,
  output logic        z
);

  state_t      r_state;
  logic [7:0]  r_m;
  logic [7:0]  r_a;
  logic [7:0]  r_q;
  logic        r_c;
  logic [3:0]  r_cnt;

  logic [7:0]  w_alu_b;
  logic [7:0]  w_s;
  logic        w_c;
  logic [1:0]  w_alu_unused;
  logic [16:0] w_shift;

  localparam logic [1:0] c_op = OP_ADD;

  assign w_alu_b = r_q[0] ? r_m : 8'h00;

  ula_8b u_ula (
    .a  (r_a),
    .b  (w_alu_b),
    .x  (c_op[1]),
    .y  (c_op[0]),
    .s  (w_s),
    .c  (w_c),
    .ov (w_alu_unused[1]),
    .n  (w_alu_unused[0])
  );

  // The carry-out lands in A[7]; the shifted-out Q[0] is discarded.
  assign w_shift = {w_c, w_s, r_q} >> 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_m     <= 8'h00;
      r_a     <= 8'h00;
      r_q     <= 8'h00;
      r_c     <= 1'b0;
      r_cnt   <= 4'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      p       <= 16'h0000;
      z       <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_m     <= a;
            r_q     <= b;
            r_a     <= 8'h00;
            r_c     <= 1'b0;
            r_cnt   <= 4'd0;
            busy    <= 1'b1;
            r_state <= CALC;
          end
        end
        CALC: begin
          {r_c, r_a, r_q} <= w_shift;
          r_cnt           <= r_cnt + 4'd1;
          if (r_cnt == ITER_LAST) begin
            p       <= w_shift[15:0];
            z       <= (w_shift[15:0] == 16'h0000);
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mult_8b_seq.sv
// ============================================================================
// tb_mult_8b_seq
// Self-checking bench for mult_8b_seq against a plain-arithmetic product model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_8b_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] p;
  logic        z;

  int n_checks = 0;
  int n_fail   = 0;

  mult_8b_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p),
    .z     (z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Launch ia*ib. inj_at: CALC cycle where a stray 9*9 start is pulsed (-1 none).
  // rst_at: CALC cycle where reset is asserted (-1 none).
  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib,
                        input int inj_at, input int rst_at);
    int          lat;
    int          bc;
    logic [15:0] exp_p;
    exp_p = 16'(ia) * 16'(ib);
    a     = ia;
    b     = ib;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
    lat = 0;
    bc  = 0;
    while (done !== 1'b1 && lat < 20) begin
      if (lat == inj_at) begin
        start = 1'b1;
        a     = 8'd9;
        b     = 8'd9;
      end else begin
        start = 1'b0;
      end
      if (lat == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_p", 32'(p), 32'd0);
        chk("abort_z", 32'(z), 32'd1);
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("abort_no_done", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        return;
      end
      if (busy === 1'b1) bc++;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk("latency", 32'(lat), 32'd8);
    chk("busy_cycles", 32'(bc), 32'd8);
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("product", 32'(p), 32'(exp_p));
    chk("zero_flag", 32'(z), 32'(exp_p == 16'h0000));
    @(negedge clk);
    chk("done_pulse_width", 32'(done), 32'd0);
    @(negedge clk);
    chk("product_held", 32'(p), 32'(exp_p));
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_p", 32'(p), 32'd0);
    chk("rst_z", 32'(z), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(8'd10, 8'd20, -1, -1);
    run_op(8'd255, 8'd255, -1, -1);
    run_op(8'd0, 8'd123, -1, -1);
    run_op(8'd123, 8'd0, -1, -1);
    run_op(8'd128, 8'd2, -1, -1);
    run_op(8'd1, 8'd255, -1, -1);
    run_op(8'd5, 8'd6, 3, -1);
    run_op(8'd9, 8'd9, -1, -1);
    run_op(8'd200, 8'd3, -1, 4);
    run_op(8'd7, 8'd7, -1, -1);

    for (int i = 0; i < 40; i++) begin
      run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), -1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

`default_nettype wire
